// File: rtl/bcd_to_bin_seq_if.sv
// Handshake bundle between the BCD entry side (master) and the BCD-to-binary converter (slave).
interface bcd_to_bin_seq_if #(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 10
);
    logic                  start;
    logic [4*DIGITS-1:0]   bcd_in;
    logic [BIN_W-1:0]      bin_out;
    logic                  busy;
    logic                  done;
    logic                  err;

    modport master (
        output start, bcd_in,
        input  bin_out, busy, done, err
    );

    modport slave (
        input  start, bcd_in,
        output bin_out, busy, done, err
    );
endinterface

// File: rtl/bcd_to_bin_seq.sv
// Sequential BCD-to-binary converter, reverse double-dabble, one bit per clock.
// Optional invalid-digit detection enabled by defining BCD2BIN_DIGIT_CHECK_EN.
module bcd_to_bin_seq #(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    bcd_to_bin_seq_if.slave   bus
);
    localparam int BCD_W = 4 * DIGITS;
    localparam int SR_W  = BCD_W + BIN_W;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [BCD_W-1:0] bcd_sr_q, bcd_sr_d;
    logic [BIN_W-1:0] bin_sr_q, bin_sr_d;
    logic [BIN_W-1:0] bin_out_q, bin_out_d;

    logic [SR_W-1:0]  sh;
    logic [BCD_W-1:0] bcd_adj;
    logic             accept;
    logic             bad_digit;

`ifdef BCD2BIN_DIGIT_CHECK_EN
    logic err_q, err_d;

    always_comb begin
        bad_digit = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bus.bcd_in[4*i +: 4] > 4'd9) begin
                bad_digit = 1'b1;
            end
        end
    end
`else
    assign bad_digit = 1'b0;
`endif

    assign accept = ((state_q == S_IDLE) || (state_q == S_DONE)) && bus.start;

    // One iteration: shift right, then pull each nibble that landed at >=8 back by 3.
    always_comb begin
        sh      = {bcd_sr_q, bin_sr_q} >> 1;
        bcd_adj = sh[SR_W-1:BIN_W];
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_adj[4*i +: 4] >= 4'd8) begin
                bcd_adj[4*i +: 4] = bcd_adj[4*i +: 4] - 4'd3;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bcd_sr_d  = bcd_sr_q;
        bin_sr_d  = bin_sr_q;
        bin_out_d = bin_out_q;
`ifdef BCD2BIN_DIGIT_CHECK_EN
        err_d     = err_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (accept) begin
                    cnt_d    = '0;
                    bcd_sr_d = bus.bcd_in;
                    bin_sr_d = '0;
`ifdef BCD2BIN_DIGIT_CHECK_EN
                    err_d    = bad_digit;
                    if (bad_digit) begin
                        state_d   = S_DONE;
                        bin_out_d = '0;
                    end else begin
                        state_d   = S_SHIFT;
                    end
`else
                    state_d  = S_SHIFT;
`endif
                end
            end
            S_SHIFT: begin
                bcd_sr_d = bcd_adj;
                bin_sr_d = sh[BIN_W-1:0];
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d   = S_DONE;
                    bin_out_d = sh[BIN_W-1:0];
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bcd_sr_q  <= '0;
            bin_sr_q  <= '0;
            bin_out_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bcd_sr_q  <= bcd_sr_d;
            bin_sr_q  <= bin_sr_d;
            bin_out_q <= bin_out_d;
        end
    end

`ifdef BCD2BIN_DIGIT_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

    assign bus.bin_out = bin_out_q;
    assign bus.busy    = (state_q == S_SHIFT);
    assign bus.done    = (state_q == S_DONE);

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Scoreboard bench for bcd_to_bin_seq: expected value, err and done cycle queued per accepted start.
module tb_bcd_to_bin_seq;
    localparam int DIGITS = 3;
    localparam int BIN_W  = 10;

    typedef struct {
        int     bin;
        int     err;
        longint cyc;
    } exp_t;

    logic   clk;
    logic   rst_n;
    longint cyc;
    int     n_chk;
    int     n_fail;
    int     done_cnt;
    int     exp_done;
    exp_t   sb[$];

    bcd_to_bin_seq_if #(.DIGITS(DIGITS), .BIN_W(BIN_W)) b ();

    bcd_to_bin_seq #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int bcd_val(input logic [11:0] v);
        return int'(v[11:8]) * 100 + int'(v[7:4]) * 10 + int'(v[3:0]);
    endfunction

    function automatic logic [11:0] to_bcd(input int i);
        return {4'(i / 100), 4'((i / 10) % 10), 4'(i % 10)};
    endfunction

    function automatic bit is_bad(input logic [11:0] v);
        return (v[11:8] > 4'd9) || (v[7:4] > 4'd9) || (v[3:0] > 4'd9);
    endfunction

    always @(posedge clk) begin
        #1;
        if (b.done === 1'b1) begin
            exp_t e;
            done_cnt++;
            if (sb.size() == 0) begin
                chk("spurious_done", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("bin_out", b.bin_out, e.bin);
                chk("err", b.err, e.err);
                chk("latency", cyc, e.cyc);
                chk("busy_at_done", b.busy, 0);
            end
        end
    end

    task automatic do_conv(input logic [11:0] v);
        exp_t e;
        int   n;
        bit   bad;
        n = 0;
        @(negedge clk);
        while (b.busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("idle_wait", 1, 0);
`ifdef BCD2BIN_DIGIT_CHECK_EN
        bad = is_bad(v);
`else
        bad = 1'b0;
`endif
        e.bin = bad ? 0 : bcd_val(v);
        e.err = bad ? 1 : 0;
        e.cyc = cyc + 1 + (bad ? 0 : BIN_W);
        sb.push_back(e);
        exp_done++;
        b.start  = 1'b1;
        b.bcd_in = v;
        @(posedge clk);
        #1;
        b.start  = 1'b0;
        b.bcd_in = 12'($urandom);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || b.busy) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("drain_timeout", 1, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int dc;
        n_chk    = 0;
        n_fail   = 0;
        done_cnt = 0;
        exp_done = 0;
        rst_n    = 1'b0;
        b.start  = 1'b0;
        b.bcd_in = '0;
        repeat (3) @(negedge clk);
        chk("rst_bin_out", b.bin_out, 0);
        chk("rst_busy", b.busy, 0);
        chk("rst_done", b.done, 0);
        chk("rst_err", b.err, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_busy", b.busy, 0);

        do_conv(12'h999);
        drain();

        do_conv(12'h000);
        do_conv(12'h512);
        drain();

        do_conv(12'h047);
        repeat (3) @(negedge clk);
        chk("busy_mid", b.busy, 1);
        b.start  = 1'b1;
        b.bcd_in = 12'h999;
        @(negedge clk);
        b.bcd_in = 12'h123;
        @(negedge clk);
        b.start  = 1'b0;
        b.bcd_in = 12'h888;
        drain();
        chk("bin_hold", b.bin_out, 47);

        do_conv(12'h255);
        repeat (4) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_bin_out", b.bin_out, 0);
        chk("arst_busy", b.busy, 0);
        chk("arst_done", b.done, 0);
        chk("arst_err", b.err, 0);
        sb.delete(sb.size() - 1);
        exp_done--;
        dc = done_cnt;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        chk("no_done_after_rst", done_cnt, dc);
        chk("idle_after_rst", b.busy, 0);

`ifdef BCD2BIN_DIGIT_CHECK_EN
        do_conv(12'h1A3);
        @(negedge clk);
        chk("bad_busy", b.busy, 0);
        do_conv(12'h100);
        drain();
`endif

        for (int i = 0; i < 1000; i++) begin
            do_conv(to_bcd(i));
        end
        drain();

        chk("sb_empty", sb.size(), 0);
        chk("done_count", done_cnt, exp_done);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
